// File: rtl/track_gen_pkg.sv
// Shared types and default constants for the track-side sensor emulator.
// Consumed by track_channel and track_sensor_gen.
package track_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int NUM_TRACKS  = 2;

    localparam int DEF_S1_DIST = 8;
    localparam int DEF_S2_DIST = 24;
    localparam int DEF_S3_DIST = 32;
    localparam int DEF_PULSE_W = 1;
    localparam int DEF_CNT_W   = 6;

endpackage

// File: rtl/track_channel.sv
// One track: IDLE/RUN FSM, position counter, S1/S3 sensor flops and gate check.
// Gate check present only when TRACK_GEN_VIOLATION_EN is defined.
module track_channel
    import track_gen_pkg::*;
#(
    parameter int S1_DIST = DEF_S1_DIST,
    parameter int S2_DIST = DEF_S2_DIST,
    parameter int S3_DIST = DEF_S3_DIST,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        launch,
    input  logic        gate_is_closed,
    input  logic        violation_clr,
    output chan_state_e state,
    output logic        s1,
    output logic        s3,
    output logic        done,
    output logic        violation
);

    localparam logic [CNT_W-1:0] S1_LO    = CNT_W'(S1_DIST);
    localparam logic [CNT_W-1:0] S1_HI    = CNT_W'(S1_DIST + PULSE_W - 1);
    localparam logic [CNT_W-1:0] S2_POS   = CNT_W'(S2_DIST);
    localparam logic [CNT_W-1:0] S3_LO    = CNT_W'(S3_DIST);
    localparam logic [CNT_W-1:0] S3_HI    = CNT_W'(S3_DIST + PULSE_W - 1);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(S3_DIST + PULSE_W - 1);

    chan_state_e      state_nxt;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] pos_nxt;
    logic             done_nxt;
    logic             s1_nxt;
    logic             s3_nxt;
    logic             run_nxt;

    // launch is a one-cycle request with no ready: it is taken only in IDLE
    // and silently dropped while a train is in flight (no queuing).
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = RUN;
                    pos_nxt   = '0;
                end
            end
            RUN: begin
                if (pos == LAST_POS) begin
                    state_nxt = IDLE;
                    pos_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    pos_nxt = pos + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = '0;
            end
        endcase

        // Sensor flops track the next position so they line up with pos.
        run_nxt = (state_nxt == RUN);
        s1_nxt  = run_nxt && (pos_nxt >= S1_LO) && (pos_nxt <= S1_HI);
        s3_nxt  = run_nxt && (pos_nxt >= S3_LO) && (pos_nxt <= S3_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            done  <= 1'b0;
            s1    <= 1'b0;
            s3    <= 1'b0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            done  <= done_nxt;
            s1    <= s1_nxt;
            s3    <= s3_nxt;
        end
    end

`ifdef TRACK_GEN_VIOLATION_EN
    logic viol_set;

    assign viol_set = (state == RUN) && (pos == S2_POS) && !gate_is_closed;

    // A set on the same edge as a clear must win.
    always_ff @(posedge clk) begin
        if (rst) begin
            violation <= 1'b0;
        end else begin
            violation <= viol_set | (violation & ~violation_clr);
        end
    end
`else
    logic unused_gate_inputs;

    assign unused_gate_inputs = ^{gate_is_closed, violation_clr};
    assign violation          = 1'b0;
`endif

endmodule

// File: rtl/track_sensor_gen.sv
// Two-track sensor emulator driving T1/T2 approach and exit sensors for the
// crossing controller. Gate check enabled by defining TRACK_GEN_VIOLATION_EN.
module track_sensor_gen
    import track_gen_pkg::*;
#(
    parameter int S1_DIST = DEF_S1_DIST,
    parameter int S2_DIST = DEF_S2_DIST,
    parameter int S3_DIST = DEF_S3_DIST,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TRACKS-1:0] launch,
    input  logic                  gate_is_closed,
    input  logic                  violation_clr,
    output logic                  T1_S1,
    output logic                  T1_S3,
    output logic                  T2_S1,
    output logic                  T2_S3,
    output logic [NUM_TRACKS-1:0] busy,
    output logic [NUM_TRACKS-1:0] done,
    output logic [NUM_TRACKS-1:0] violation
);

    chan_state_e           ch_state [NUM_TRACKS];
    logic [NUM_TRACKS-1:0] s1;
    logic [NUM_TRACKS-1:0] s3;

    for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_track
        track_channel #(
            .S1_DIST (S1_DIST),
            .S2_DIST (S2_DIST),
            .S3_DIST (S3_DIST),
            .PULSE_W (PULSE_W),
            .CNT_W   (CNT_W)
        ) u_channel (
            .clk            (clk),
            .rst            (rst),
            .launch         (launch[i]),
            .gate_is_closed (gate_is_closed),
            .violation_clr  (violation_clr),
            .state          (ch_state[i]),
            .s1             (s1[i]),
            .s3             (s3[i]),
            .done           (done[i]),
            .violation      (violation[i])
        );

        assign busy[i] = (ch_state[i] == RUN);
    end

    assign T1_S1 = s1[0];
    assign T1_S3 = s3[0];
    assign T2_S1 = s1[1];
    assign T2_S3 = s3[1];

endmodule
